laser_cover_counter: RTL



---
 rtl/laser_cover_counter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/laser_cover_counter.sv
// Scans the stored LASER points and counts those inside a radius-4 circle.
// Define LASER_BEST_TRACK_EN to keep the best candidate seen so far.
module laser_cover_counter #(
    parameter int NPTS = 40,
    parameter int R2   = 16,
    parameter int IDXW = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [3:0]      CX,
    input  logic [3:0]      CY,
    input  logic            OTHER_EN,
    input  logic [3:0]      OX,
    input  logic [3:0]      OY,
    output logic [IDXW-1:0] RD_IDX,
    input  logic [3:0]      RD_X,
    input  logic [3:0]      RD_Y,
    output logic            BUSY,
    output logic            VALID,
    output logic [IDXW-1:0] COUNT
`ifdef LASER_BEST_TRACK_EN
    ,
    input  logic            BEST_CLR,
    output logic [3:0]      BEST_CX,
    output logic [3:0]      BEST_CY,
    output logic [IDXW-1:0] BEST_CNT
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [IDXW-1:0] LAST = IDXW'(NPTS - 1);

    state_t          state;
    logic [3:0]      cx_q;
    logic [3:0]      cy_q;
    logic [3:0]      ox_q;
    logic [3:0]      oy_q;
    logic            oen_q;
    logic            dv;
    logic [IDXW-1:0] acc;
    logic            hit;
    logic [IDXW-1:0] acc_next;

    function automatic logic in_circle(
        input logic [3:0] px,
        input logic [3:0] py,
        input logic [3:0] cx,
        input logic [3:0] cy
    );
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        logic [8:0] d2;
        dx = (px >= cx) ? px - cx : cx - px;
        dy = (py >= cy) ? py - cy : cy - py;
        sx = {4'b0, dx} * {4'b0, dx};
        sy = {4'b0, dy} * {4'b0, dy};
        d2 = {1'b0, sx} + {1'b0, sy};
        return d2 <= 9'(R2);
    endfunction

    // dv marks cycles where RD_X/RD_Y carry the point issued one cycle earlier
    always_comb begin
        hit = dv & (in_circle(RD_X, RD_Y, cx_q, cy_q) |
                    (oen_q & in_circle(RD_X, RD_Y, ox_q, oy_q)));
        acc_next = acc + {{(IDXW-1){1'b0}}, hit};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            cx_q   <= '0;
            cy_q   <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            oen_q  <= 1'b0;
            dv     <= 1'b0;
            acc    <= '0;
            RD_IDX <= '0;
            BUSY   <= 1'b0;
            VALID  <= 1'b0;
            COUNT  <= '0;
`ifdef LASER_BEST_TRACK_EN
            BEST_CX  <= '0;
            BEST_CY  <= '0;
            BEST_CNT <= '0;
`endif
        end else begin
            dv  <= (state == ISSUE);
            acc <= acc_next;
            unique case (state)
                IDLE: begin
                    RD_IDX <= '0;
                    if (START) begin
                        cx_q  <= CX;
                        cy_q  <= CY;
                        ox_q  <= OX;
                        oy_q  <= OY;
                        oen_q <= OTHER_EN;
                        acc   <= '0;
                        COUNT <= '0;
                        BUSY  <= 1'b1;
                        state <= ISSUE;
                    end
`ifdef LASER_BEST_TRACK_EN
                    if (BEST_CLR) begin
                        BEST_CX  <= '0;
                        BEST_CY  <= '0;
                        BEST_CNT <= '0;
                    end
`endif
                end
                ISSUE: begin
                    if (RD_IDX == LAST) begin
                        RD_IDX <= '0;
                        state  <= DRAIN;
                    end else begin
                        RD_IDX <= RD_IDX + 1'b1;
                    end
                end
                DRAIN: begin
                    COUNT <= acc_next;
                    VALID <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    VALID <= 1'b0;
                    state <= IDLE;
`ifdef LASER_BEST_TRACK_EN
                    // strict compare keeps the earlier candidate on a tie
                    if (COUNT > BEST_CNT) begin
                        BEST_CNT <= COUNT;
                        BEST_CX  <= cx_q;
                        BEST_CY  <= cy_q;
                    end
`endif
                end
            endcase
        end
    end

endmodule
